// File: rtl/fsm_seq_arbiter_if.sv
// Bundle between requesters, the arbiter and the shared condition/acknowledge target.
// Latency and backpressure are set by the arbiter; this interface only groups the wires.
interface fsm_seq_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       busy;
    logic       tgt_rst;
    logic       c1_o;
    logic       c2_o;
    logic       i_o;
    logic [1:0] sts;
    logic       done;
    logic       err;

    modport master (
        output req, sts,
        input  gnt, busy, tgt_rst, c1_o, c2_o, i_o, done, err
    );

    modport slave (
        input  req, sts,
        output gnt, busy, tgt_rst, c1_o, c2_o, i_o, done, err
    );
endinterface

// File: rtl/fsm_seq_arbiter.sv
// Round-robin sequencer sharing one C1/C2/I target: clear, two ordered strobes, wait for sts==11.
// Request-to-done latency CLR_CYCLES+4 minimum; req is only sampled in IDLE, so requesters simply wait.
module fsm_seq_arbiter #(
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    fsm_seq_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COND_A,
        S_COND_B,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       tgt_rst_q, tgt_rst_d;
    logic       c1_q, c1_d;
    logic       c2_q, c2_d;
    logic       i_q, i_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d = S_CLEAR;
                    cnt_d   = 8'd0;
                    if (bus.req == 2'b11)
                        gnt_d = last_q ? 2'b01 : 2'b10;
                    else
                        gnt_d = bus.req;
                end
            end
            S_CLEAR: begin
                if (cnt_q == 8'(CLR_CYCLES - 1)) begin
                    state_d = S_COND_A;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_COND_A: state_d = S_COND_B;
            S_COND_B: begin
                state_d = S_WAIT;
                cnt_d   = 8'd0;
            end
            S_WAIT: begin
                // Success is tested first so it wins over a coincident timeout.
                if (bus.sts == 2'b11) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_FINISH: begin
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        // Outputs are decoded from the next state so the registered copy lines up with the state.
        busy_d    = (state_d != S_IDLE);
        tgt_rst_d = (state_d == S_CLEAR);
        i_d       = (state_d == S_WAIT);
        c1_d      = ((state_d == S_COND_A) && gnt_d[1]) || ((state_d == S_COND_B) && gnt_d[0]);
        c2_d      = ((state_d == S_COND_A) && gnt_d[0]) || ((state_d == S_COND_B) && gnt_d[1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            gnt_q     <= 2'b00;
            last_q    <= 1'b1;
            busy_q    <= 1'b0;
            tgt_rst_q <= 1'b0;
            c1_q      <= 1'b0;
            c2_q      <= 1'b0;
            i_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            tgt_rst_q <= tgt_rst_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            i_q       <= i_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.tgt_rst = tgt_rst_q;
    assign bus.c1_o    = c1_q;
    assign bus.c2_o    = c2_q;
    assign bus.i_o     = i_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_fsm_seq_arbiter.sv
// Directed bench for fsm_seq_arbiter with default parameters (TIMEOUT=15, CLR_CYCLES=2).
module tb_fsm_seq_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fsm_seq_arbiter_if bus ();

    fsm_seq_arbiter #(.TIMEOUT(15), .CLR_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] gnt_first;
        logic [1:0] gnt_fin;
        int         n_rst;
        int         n_i;
        int         n_c1;
        int         n_c2;
        int         n_done;
        int         n_err;
        int         first_strobe;
        int         lat;
        logic       both;
        logic       timed_out;
    } obs_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one sequence from IDLE and records what the outputs did, up to and including FINISH.
    // sts_w is the WAIT cycle index on which sts=11 is presented (-1: never).
    task automatic observe_seq(input logic [1:0] req_v, input bit hold, input int sts_w,
                               input bit early, output obs_t o);
        bit fin;
        o = '0;
        fin = 1'b0;
        bus.req = req_v;
        bus.sts = 2'b00;
        for (int n = 1; n <= 60 && !fin; n++) begin
            tick();
            if (n == 1) begin
                o.gnt_first = bus.gnt;
                if (!hold) bus.req = 2'b00;
            end
            if (bus.tgt_rst) o.n_rst++;
            if (bus.i_o)     o.n_i++;
            if (bus.c1_o)    o.n_c1++;
            if (bus.c2_o)    o.n_c2++;
            if (bus.done)    o.n_done++;
            if (bus.err)     o.n_err++;
            if (bus.c1_o && bus.c2_o) o.both = 1'b1;
            if (o.first_strobe == 0) begin
                if (bus.c1_o)      o.first_strobe = 1;
                else if (bus.c2_o) o.first_strobe = 2;
            end
            if (bus.done || bus.err) begin
                o.gnt_fin = bus.gnt;
                o.lat = n;
                fin = 1'b1;
                bus.sts = 2'b00;
            end else if (bus.i_o && (o.n_i - 1) == sts_w) begin
                bus.sts = 2'b11;
            end else if (early && (bus.tgt_rst || bus.c1_o || bus.c2_o)) begin
                bus.sts = 2'b11;
            end else begin
                bus.sts = 2'b00;
            end
        end
        o.timed_out = !fin;
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        bus.req = 2'b11;
        bus.sts = 2'b11;
        repeat (3) tick();
        n_cmp++;
        if ({bus.gnt, bus.busy, bus.tgt_rst, bus.c1_o, bus.c2_o, bus.i_o, bus.done, bus.err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {bus.gnt, bus.busy, bus.tgt_rst, bus.c1_o, bus.c2_o, bus.i_o, bus.done, bus.err});
        end
        rst = 1'b0;
        observe_seq(2'b11, 1'b0, 0, 1'b0, o);
        n_cmp++;
        if (o.gnt_first !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 01", o.gnt_first);
        end
        tick();
    endtask

    task automatic test_single();
        obs_t o;
        observe_seq(2'b01, 1'b0, 2, 1'b0, o);
        n_cmp++;
        if (o.timed_out !== 1'b0) begin n_fail++; $display("FAIL single_finish: no done/err within budget"); end
        n_cmp++;
        if (o.gnt_first !== 2'b01 || o.n_rst != 2) begin
            n_fail++; $display("FAIL single_clear: gnt %b tgt_rst cycles %0d want 01 / 2", o.gnt_first, o.n_rst);
        end
        n_cmp++;
        if (o.first_strobe != 2 || o.n_c1 != 1 || o.n_c2 != 1 || o.both) begin
            n_fail++;
            $display("FAIL single_strobes: first %0d c1 %0d c2 %0d both %b want 2 1 1 0",
                     o.first_strobe, o.n_c1, o.n_c2, o.both);
        end
        n_cmp++;
        if (o.n_i != 3 || o.n_done != 1 || o.n_err != 0 || o.gnt_fin !== 2'b01 || o.lat != 8) begin
            n_fail++;
            $display("FAIL single_wait: i %0d done %0d err %0d gnt %b lat %0d want 3 1 0 01 8",
                     o.n_i, o.n_done, o.n_err, o.gnt_fin, o.lat);
        end
        tick();
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: gnt %b busy %b done %b err %b want 00 0 0 0",
                     bus.gnt, bus.busy, bus.done, bus.err);
        end
    endtask

    task automatic test_contention();
        obs_t o;
        logic [1:0] exp_g [3] = '{2'b10, 2'b01, 2'b10};
        // last is 0 after test_single served requester 0, so requester 1 goes first here.
        for (int s = 0; s < 3; s++) begin
            observe_seq(2'b11, 1'b1, 0, 1'b0, o);
            n_cmp++;
            if (o.gnt_first !== exp_g[s] || o.gnt_fin !== exp_g[s] || o.n_done != 1) begin
                n_fail++;
                $display("FAIL contention_grant%0d: gnt %b/%b done %0d want %b 1",
                         s, o.gnt_first, o.gnt_fin, o.n_done, exp_g[s]);
            end
            n_cmp++;
            if (o.first_strobe != (exp_g[s][1] ? 1 : 2) || o.both) begin
                n_fail++;
                $display("FAIL contention_order%0d: first %0d both %b want %0d 0",
                         s, o.first_strobe, o.both, exp_g[s][1] ? 1 : 2);
            end
            tick();
            n_cmp++;
            if (bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL contention_idle%0d: gnt %b busy %b want 00 0", s, bus.gnt, bus.busy);
            end
        end
        bus.req = 2'b00;
    endtask

    task automatic test_timeout();
        obs_t o;
        observe_seq(2'b01, 1'b0, -1, 1'b0, o);
        n_cmp++;
        if (o.n_i != 15 || o.n_err != 1 || o.n_done != 0 || o.lat != 20 || o.timed_out) begin
            n_fail++;
            $display("FAIL timeout: i %0d err %0d done %0d lat %0d to %b want 15 1 0 20 0",
                     o.n_i, o.n_err, o.n_done, o.lat, o.timed_out);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        obs_t o;
        observe_seq(2'b10, 1'b0, 14, 1'b0, o);
        n_cmp++;
        if (o.n_done != 1 || o.n_err != 0 || o.n_i != 15 || o.lat != 20 || o.gnt_fin !== 2'b10) begin
            n_fail++;
            $display("FAIL simult_success: done %0d err %0d i %0d lat %0d gnt %b want 1 0 15 20 10",
                     o.n_done, o.n_err, o.n_i, o.lat, o.gnt_fin);
        end
        tick();
        observe_seq(2'b01, 1'b0, -1, 1'b1, o);
        n_cmp++;
        if (o.n_done != 0 || o.n_err != 1 || o.n_i != 15) begin
            n_fail++;
            $display("FAIL early_sts_ignored: done %0d err %0d i %0d want 0 1 15", o.n_done, o.n_err, o.n_i);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit seen = 1'b0;
        bus.req = 2'b10;
        bus.sts = 2'b00;
        tick();
        bus.req = 2'b00;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (bus.i_o) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen || bus.gnt !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_wait: reached %b gnt %b want 1 10", seen, bus.gnt);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.gnt, bus.busy, bus.tgt_rst, bus.c1_o, bus.c2_o, bus.i_o, bus.done, bus.err} !== 9'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b want 000000000",
                     {bus.gnt, bus.busy, bus.tgt_rst, bus.c1_o, bus.c2_o, bus.i_o, bus.done, bus.err});
        end
        tick();
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_nopulse: done %b err %b want 0 0", bus.done, bus.err);
        end
        rst = 1'b0;
        observe_seq(2'b11, 1'b0, 1, 1'b0, o);
        n_cmp++;
        if (o.gnt_first !== 2'b01 || o.n_done != 1) begin
            n_fail++; $display("FAIL rstmid_regrant: gnt %b done %0d want 01 1", o.gnt_first, o.n_done);
        end
        tick();
    endtask

    initial begin
        bus.req = 2'b00;
        bus.sts = 2'b00;
        rst = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
